// File: rtl/uart_echo_bridge_pkg.sv
// Shared encodings for the UART echo bridge: transform modes, FSM states and
// the control characters used by the optional CR -> CR LF expansion
// (enabled by defining CRLF_EXPAND_EN).
package uart_echo_bridge_pkg;

  // Byte transform selected by the mode input
  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_UPPER = 2'd1;
  localparam logic [1:0] MODE_INV   = 2'd2;
  localparam logic [1:0] MODE_INC   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_LF
  } state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Distance between ASCII lower- and upper-case letters
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth. The head entry is presented
// combinationally on o_rdata. The caller must never push when full without a
// simultaneous pop, nor pop when empty.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [DATA_W-1:0]      i_wdata,
  output logic [DATA_W-1:0]      o_rdata,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;

  // Storage write; contents need no reset since the level gates validity
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; level tracks occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/uart_echo_bridge.sv
// Receive-to-transmit bridge: buffers received characters in a FIFO, applies
// a selectable transform at pop time and hands them to the UART transmitter.
// Defining CRLF_EXPAND_EN makes every transmitted CR be followed by an LF.
module uart_echo_bridge
  import uart_echo_bridge_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx_valid,
  input  logic [DATA_W-1:0]      i_rx_data,
  input  logic                   i_rx_error,
  input  logic                   i_tx_busy,
  output logic                   o_tx_start,
  output logic [DATA_W-1:0]      o_tx_data,
  input  logic [1:0]             i_mode,
  input  logic                   i_clr_ovf,
  output logic [$clog2(DEPTH):0] o_fifo_level,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic [CNT_W-1:0]       o_rx_count,
  output logic [CNT_W-1:0]       o_tx_count
);

  localparam int unsigned TMR_W = $clog2(START_TIMEOUT + 1);

  state_e            r_state;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic [CNT_W-1:0]  r_tx_count;
  logic [CNT_W-1:0]  r_rx_count;
  logic              r_overflow;
  logic [TMR_W-1:0]  r_timer;
`ifdef CRLF_EXPAND_EN
  logic              r_lf_pend;
`endif

  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_upper;
  logic [DATA_W-1:0] w_xform;

  assign w_pop  = (r_state == S_IDLE) && !w_empty && !i_tx_busy;
  // A full FIFO still accepts a character when the head leaves in the same cycle
  assign w_push = i_rx_valid && !i_rx_error && (!w_full || w_pop);
  assign w_drop = i_rx_valid && !i_rx_error && w_full && !w_pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (i_rx_data),
    .o_rdata (w_head),
    .o_level (o_fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Case folding only makes sense for 8-bit ASCII characters
  if (DATA_W == 8) begin : g_upper
    assign w_upper = is_lower(w_head) ? (w_head - CASE_OFFSET) : w_head;
  end else begin : g_upper_pass
    assign w_upper = w_head;
  end

  // Transform of the FIFO head, using the mode of the popping cycle
  always_comb begin
    w_xform = w_head;
    unique case (i_mode)
      MODE_PASS:  w_xform = w_head;
      MODE_UPPER: w_xform = w_upper;
      MODE_INV:   w_xform = ~w_head;
      MODE_INC:   w_xform = w_head + DATA_W'(1);
      default:    w_xform = w_head;
    endcase
  end

  // Transmit handshake FSM with registered tx_start/tx_data/tx_count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_tx_count <= '0;
      r_timer    <= '0;
`ifdef CRLF_EXPAND_EN
      r_lf_pend  <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_xform;
            r_tx_start <= 1'b1;
            r_timer    <= '0;
            r_state    <= S_START;
            if (r_tx_count != '1) begin
              r_tx_count <= r_tx_count + CNT_W'(1);
            end
`ifdef CRLF_EXPAND_EN
            r_lf_pend  <= (DATA_W == 8) && (w_xform == DATA_W'(CR));
`endif
          end
        end
        S_START: begin
          // A transmitter that never acknowledges must not stall the bridge
          if (i_tx_busy) begin
            r_state <= S_BUSY;
          end else if (r_timer == TMR_W'(START_TIMEOUT - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_BUSY: begin
          if (!i_tx_busy) begin
`ifdef CRLF_EXPAND_EN
            r_state <= r_lf_pend ? S_LF : S_IDLE;
`else
            r_state <= S_IDLE;
`endif
          end
        end
`ifdef CRLF_EXPAND_EN
        S_LF: begin
          // Inserted LF does not consume a FIFO entry
          if (!i_tx_busy) begin
            r_tx_data  <= DATA_W'(LF);
            r_tx_start <= 1'b1;
            r_timer    <= '0;
            r_lf_pend  <= 1'b0;
            r_state    <= S_START;
            if (r_tx_count != '1) begin
              r_tx_count <= r_tx_count + CNT_W'(1);
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Receive counter and sticky overflow flag; a drop wins over a clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_count <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && (r_rx_count != '1)) begin
        r_rx_count <= r_rx_count + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;
  assign o_rx_count = r_rx_count;
  assign o_tx_count = r_tx_count;

endmodule
